campfire_checkpoint: RTL and testbench

CAMPFIRE_CHECKPOINT -- requirements
Module: campfire_checkpoint

---
 rtl/campfire_checkpoint.sv | 152 +++++++++++++++
 tb/tb_campfire_checkpoint.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/campfire_checkpoint.sv
// Campfire checkpoint: lights after a run of consecutive player overlaps, then latches
// the respawn point, issues respawn commands on death and animates the flame.
module campfire_checkpoint #(
    parameter int         SIZE       = 16,
    parameter int         ARM_CYCLES = 4,
    parameter int         FLAME_DIV  = 16,
    parameter logic [9:0] START_X    = 10'd20,
    parameter logic [9:0] START_Y    = 10'd180
) (
    input  logic        sim_clk,
    input  logic        reset,
    input  logic [31:0] campfireState,
    input  logic [31:0] playerState,
    input  logic        player_dead,
    output logic [31:0] respawnState,
    output logic        lit,
    output logic        respawn_req,
    output logic [1:0]  flameFrame
);

    localparam int ARM_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES + 1) : 1;
    localparam int DIV_W = (FLAME_DIV > 1) ? $clog2(FLAME_DIV) : 1;
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_CYCLES - 1);
    localparam logic [ARM_W-1:0] ARM_ONE  = ARM_W'(1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FLAME_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [10:0]      SIZE_11  = 11'(SIZE);

    typedef enum logic [1:0] {
        ST_UNLIT  = 2'd0,
        ST_ARMING = 2'd1,
        ST_LIT    = 2'd2
    } state_t;

    // Distance between two coordinates, larger minus smaller, one extra bit so it never wraps.
    function automatic logic [10:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        logic [10:0] d;
        if (a >= b) begin
            d = {1'b0, a} - {1'b0, b};
        end else begin
            d = {1'b0, b} - {1'b0, a};
        end
        return d;
    endfunction

    state_t           state_r;
    state_t           state_next_s;
    logic [ARM_W-1:0] arm_cnt_r;
    logic [ARM_W-1:0] arm_cnt_next_s;
    logic             lit_r;
    logic             respawn_req_r;
    logic [31:0]      respawn_r;
    logic [DIV_W-1:0] div_r;
    logic [1:0]       frame_r;
    logic [10:0]      dx_s;
    logic [10:0]      dy_s;
    logic             overlap_s;
    logic             unused_s;

    assign dx_s      = abs_diff(playerState[31:22], campfireState[31:22]);
    assign dy_s      = abs_diff(playerState[21:12], campfireState[21:12]);
    assign overlap_s = (dx_s < SIZE_11) && (dy_s < SIZE_11);
    assign unused_s  = ^{campfireState[11:0], playerState[11:0]};

    // Next-state logic; a death pulse always wins over an arming overlap.
    always_comb begin
        state_next_s   = state_r;
        arm_cnt_next_s = arm_cnt_r;
        case (state_r)
            ST_UNLIT: begin
                if (player_dead) begin
                    state_next_s   = ST_UNLIT;
                    arm_cnt_next_s = '0;
                end else if (overlap_s) begin
                    if (ARM_CYCLES <= 1) begin
                        state_next_s   = ST_LIT;
                        arm_cnt_next_s = '0;
                    end else begin
                        state_next_s   = ST_ARMING;
                        arm_cnt_next_s = ARM_ONE;
                    end
                end else begin
                    state_next_s   = ST_UNLIT;
                    arm_cnt_next_s = '0;
                end
            end
            ST_ARMING: begin
                if (player_dead || !overlap_s) begin
                    state_next_s   = ST_UNLIT;
                    arm_cnt_next_s = '0;
                end else if (arm_cnt_r == ARM_LAST) begin
                    state_next_s   = ST_LIT;
                    arm_cnt_next_s = '0;
                end else begin
                    state_next_s   = ST_ARMING;
                    arm_cnt_next_s = arm_cnt_r + ARM_ONE;
                end
            end
            ST_LIT: begin
                state_next_s   = ST_LIT;
                arm_cnt_next_s = arm_cnt_r;
            end
            default: begin
                state_next_s   = ST_UNLIT;
                arm_cnt_next_s = '0;
            end
        endcase
    end

    // State, lit flag, respawn point and respawn command registers.
    always_ff @(posedge sim_clk) begin
        if (reset) begin
            state_r       <= ST_UNLIT;
            arm_cnt_r     <= '0;
            lit_r         <= 1'b0;
            respawn_req_r <= 1'b0;
            respawn_r     <= {START_X, START_Y, 12'h000};
        end else begin
            state_r       <= state_next_s;
            arm_cnt_r     <= arm_cnt_next_s;
            lit_r         <= (state_next_s == ST_LIT);
            respawn_req_r <= player_dead;
            if ((state_r != ST_LIT) && (state_next_s == ST_LIT)) begin
                respawn_r <= {campfireState[31:22], campfireState[21:12], 12'h000};
            end
        end
    end

    // Flame animation: frame advances every FLAME_DIV cycles while lit, parked at 0 otherwise.
    always_ff @(posedge sim_clk) begin
        if (reset) begin
            div_r   <= '0;
            frame_r <= 2'd0;
        end else if (lit_r) begin
            if (div_r == DIV_LAST) begin
                div_r   <= '0;
                frame_r <= frame_r + 2'd1;
            end else begin
                div_r   <= div_r + DIV_ONE;
            end
        end else begin
            div_r   <= '0;
            frame_r <= 2'd0;
        end
    end

    assign respawnState = respawn_r;
    assign lit          = lit_r;
    assign respawn_req  = respawn_req_r;
    assign flameFrame   = frame_r;

endmodule

// File: tb/tb_campfire_checkpoint.sv
// Self-checking bench for campfire_checkpoint: directed scenarios followed by random
// stimulus, every cycle compared against a cycle-level behavioural model.
module tb_campfire_checkpoint;

    localparam int ARM = 4;
    localparam int DIV = 16;

    logic        sim_clk = 1'b0;
    logic        reset;
    logic [31:0] campfireState;
    logic [31:0] playerState;
    logic        player_dead;
    logic [31:0] respawnState;
    logic        lit;
    logic        respawn_req;
    logic [1:0]  flameFrame;

    int checks   = 0;
    int failures = 0;

    int m_run;
    bit m_lit;
    int m_rx;
    int m_ry;
    bit m_req;
    int m_lit_edges;

    campfire_checkpoint dut (
        .sim_clk       (sim_clk),
        .reset         (reset),
        .campfireState (campfireState),
        .playerState   (playerState),
        .player_dead   (player_dead),
        .respawnState  (respawnState),
        .lit           (lit),
        .respawn_req   (respawn_req),
        .flameFrame    (flameFrame)
    );

    always #5 sim_clk = ~sim_clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack(input logic [9:0] x, input logic [9:0] y);
        logic [11:0] junk;
        junk = 12'($urandom);
        return {x, y, junk};
    endfunction

    // Reference behaviour for one rising edge, using the inputs presented before it.
    task automatic model_edge();
        int dx;
        int dy;
        bit ovl;
        dx  = int'(campfireState[31:22]) - int'(playerState[31:22]);
        dy  = int'(campfireState[21:12]) - int'(playerState[21:12]);
        if (dx < 0) dx = -dx;
        if (dy < 0) dy = -dy;
        ovl = (dx < 16) && (dy < 16);
        if (reset) begin
            m_run = 0; m_lit = 0; m_rx = 20; m_ry = 180; m_req = 0; m_lit_edges = 0;
        end else begin
            m_req = player_dead;
            if (m_lit) begin
                m_lit_edges++;
            end else if (player_dead || !ovl) begin
                m_run = 0;
            end else begin
                m_run++;
                if (m_run >= ARM) begin
                    m_lit = 1; m_lit_edges = 0; m_run = 0;
                    m_rx = int'(campfireState[31:22]);
                    m_ry = int'(campfireState[21:12]);
                end
            end
        end
    endtask

    task automatic step(input bit rst, input logic [9:0] cx, input logic [9:0] cy,
                        input logic [9:0] px, input logic [9:0] py, input bit dead);
        logic [9:0] ex_x;
        logic [9:0] ex_y;
        int frame;
        reset         = rst;
        campfireState = pack(cx, cy);
        playerState   = pack(px, py);
        player_dead   = dead;
        @(posedge sim_clk);
        model_edge();
        #1;
        ex_x  = 10'(m_rx);
        ex_y  = 10'(m_ry);
        frame = m_lit ? ((m_lit_edges / DIV) % 4) : 0;
        check_val("lit", {31'd0, lit}, {31'd0, m_lit});
        check_val("respawnState", respawnState, {ex_x, ex_y, 12'h000});
        check_val("respawn_req", {31'd0, respawn_req}, {31'd0, m_req});
        check_val("flameFrame", {30'd0, flameFrame}, 32'(frame));
    endtask

    task automatic hold(input int n, input bit rst, input logic [9:0] cx, input logic [9:0] cy,
                        input logic [9:0] px, input logic [9:0] py, input bit dead);
        for (int i = 0; i < n; i++) begin
            step(rst, cx, cy, px, py, dead);
        end
    endtask

    initial begin
        logic [9:0] rcx;
        logic [9:0] rcy;
        logic [9:0] rpx;
        logic [9:0] rpy;
        reset = 1'b1; campfireState = '0; playerState = '0; player_dead = 1'b0;
        m_run = 0; m_lit = 0; m_rx = 20; m_ry = 180; m_req = 0; m_lit_edges = 0;

        hold(10, 1'b1, 10'd250, 10'd180, 10'd20, 10'd180, 1'b0);
        hold(6, 1'b0, 10'd250, 10'd180, 10'd266, 10'd180, 1'b0);
        hold(3, 1'b0, 10'd250, 10'd180, 10'd250, 10'd196, 1'b0);
        hold(3, 1'b0, 10'd250, 10'd180, 10'd245, 10'd175, 1'b0);
        hold(1, 1'b0, 10'd250, 10'd180, 10'd20, 10'd180, 1'b0);
        hold(3, 1'b0, 10'd250, 10'd180, 10'd245, 10'd175, 1'b0);
        hold(1, 1'b0, 10'd250, 10'd180, 10'd245, 10'd175, 1'b0);
        hold(64, 1'b0, 10'd250, 10'd180, 10'd245, 10'd175, 1'b0);
        hold(2, 1'b0, 10'd100, 10'd50, 10'd20, 10'd180, 1'b0);
        hold(1, 1'b0, 10'd100, 10'd50, 10'd100, 10'd50, 1'b1);
        hold(3, 1'b0, 10'd100, 10'd50, 10'd100, 10'd50, 1'b0);
        hold(1, 1'b1, 10'd250, 10'd180, 10'd245, 10'd175, 1'b0);

        hold(3, 1'b0, 10'd250, 10'd180, 10'd245, 10'd175, 1'b0);
        hold(1, 1'b0, 10'd250, 10'd180, 10'd245, 10'd175, 1'b1);
        hold(3, 1'b0, 10'd250, 10'd180, 10'd20, 10'd180, 1'b0);

        hold(2, 1'b0, 10'd250, 10'd180, 10'd245, 10'd175, 1'b0);
        hold(1, 1'b1, 10'd250, 10'd180, 10'd245, 10'd175, 1'b0);
        hold(3, 1'b0, 10'd250, 10'd180, 10'd20, 10'd180, 1'b1);
        hold(1, 1'b0, 10'd250, 10'd180, 10'd20, 10'd180, 1'b1);
        hold(1, 1'b1, 10'd250, 10'd180, 10'd20, 10'd180, 1'b0);
        hold(4, 1'b0, 10'd250, 10'd180, 10'd264, 10'd166, 1'b0);
        hold(2, 1'b0, 10'd250, 10'd180, 10'd20, 10'd180, 1'b0);

        rcx = 10'd250;
        rcy = 10'd180;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                rcx = 10'($urandom_range(30, 990));
                rcy = 10'($urandom_range(30, 990));
            end
            rpx = 10'(int'(rcx) + int'($urandom_range(0, 40)) - 20);
            rpy = 10'(int'(rcy) + int'($urandom_range(0, 40)) - 20);
            step($urandom_range(0, 79) == 0, rcx, rcy, rpx, rpy, $urandom_range(0, 15) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
